audio_echo: RTL and testbench

AUDIO_ECHO -- requirements
Module: audio_echo

---
 rtl/audio_echo.sv | 104 ++++++++++
 tb/tb_audio_echo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/audio_echo.sv
// audio_echo: single-tap echo mixer with a DEPTH-sample circular history buffer.
// Each accepted sample is mixed with an attenuated delayed sample and written back to the buffer.
`default_nettype none

module audio_echo #(
  parameter int DEPTH = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] sample_in,
  input  logic               new_frame,
  input  logic               echo_en,
  input  logic        [1:0]  delay_sel,
  input  logic        [1:0]  atten,
  input  logic               flush,
  output logic signed [15:0] sample_out,
  output logic               out_valid
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] DLY_QUARTER = AW'(DEPTH / 4);
  localparam logic [AW-1:0] DLY_HALF    = AW'(DEPTH / 2);
  localparam logic [AW-1:0] DLY_3Q      = AW'((3 * DEPTH) / 4);
  localparam logic [AW-1:0] DLY_MAX     = AW'(DEPTH - 1);

  logic signed [15:0] mem [0:DEPTH-1];

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      fill;
  logic [AW-1:0]      delay;
  logic [AW-1:0]      rd_addr;
  logic signed [15:0] delayed;
  logic signed [15:0] shifted;
  logic        [2:0]  shamt;
  logic signed [16:0] sum;
  logic signed [15:0] sat;
  logic signed [15:0] mix;

  always_comb begin
    delay = DLY_QUARTER;
    case (delay_sel)
      2'd0:    delay = DLY_QUARTER;
      2'd1:    delay = DLY_HALF;
      2'd2:    delay = DLY_3Q;
      default: delay = DLY_MAX;
    endcase
  end

  assign rd_addr = wr_ptr - delay;

  // A flush in the same cycle discards history before this sample sees it.
  always_comb begin
    delayed = 16'sd0;
    if (!flush && (fill >= delay)) begin
      delayed = mem[rd_addr];
    end
  end

  assign shamt   = {1'b0, atten} + 3'd1;
  assign shifted = delayed >>> shamt;
  assign sum     = {sample_in[15], sample_in} + {shifted[15], shifted};

  always_comb begin
    sat = sum[15:0];
    if (sum[16] != sum[15]) begin
      sat = sum[16] ? 16'sh8000 : 16'sh7FFF;
    end
  end

  assign mix = echo_en ? sat : sample_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sample_out <= 16'sd0;
      out_valid  <= 1'b0;
      wr_ptr     <= '0;
      fill       <= '0;
    end else begin
      out_valid <= new_frame;
      if (new_frame) begin
        sample_out <= mix;
        wr_ptr     <= wr_ptr + 1'b1;
        if (flush) begin
          fill <= AW'(1);
        end else if (fill != DLY_MAX) begin
          fill <= fill + 1'b1;
        end
      end else if (flush) begin
        fill <= '0;
      end
    end
  end

  // History is never cleared; the fill counter masks stale words.
  always_ff @(posedge clk) begin
    if (reset && new_frame) begin
      mem[wr_ptr] <= mix;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_echo.sv
// tb_audio_echo: scoreboard bench for audio_echo at DEPTH=16 with a queue-based history model.
`default_nettype none

module tb_audio_echo;

  localparam int DEPTH   = 16;
  localparam int NOMODEL = 999999;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic               new_frame = 1'b0;
  logic               echo_en = 1'b0;
  logic        [1:0]  delay_sel = 2'd0;
  logic        [1:0]  atten = 2'd0;
  logic               flush = 1'b0;
  logic signed [15:0] sample_out;
  logic               out_valid;

  int vectors    = 0;
  int miscompares = 0;
  int hist[$];
  int exp_q[$];
  int last_out = 0;

  audio_echo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .sample_in  (sample_in),
    .new_frame  (new_frame),
    .echo_en    (echo_en),
    .delay_sel  (delay_sel),
    .atten      (atten),
    .flush      (flush),
    .sample_out (sample_out),
    .out_valid  (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int delay_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return DEPTH / 4;
      2'd1:    return DEPTH / 2;
      2'd2:    return (3 * DEPTH) / 4;
      default: return DEPTH - 1;
    endcase
  endfunction

  // Reference: history is the list of mixes written since the last flush/reset.
  function automatic int model_frame(input int s, input bit fl);
    int d, dl, m;
    d  = delay_of(delay_sel);
    dl = 0;
    if (fl) hist.delete();
    if (hist.size() >= d) dl = hist[hist.size() - d];
    if (echo_en) begin
      m = s + (dl >>> (atten + 1));
      if (m > 32767) m = 32767;
      if (m < -32768) m = -32768;
    end else begin
      m = s;
    end
    hist.push_back(m);
    if (hist.size() > 32) void'(hist.pop_front());
    return m;
  endfunction

  task automatic step(input bit nf, input bit fl, input int s, input int want, input string tag);
    int m, e;
    bit exp_v;
    @(negedge clk);
    new_frame = nf;
    flush     = fl;
    sample_in = 16'(s);
    exp_v     = rst_n && nf;
    if (!rst_n) begin
      hist.delete();
      exp_q.delete();
      last_out = 0;
    end else if (nf) begin
      m = model_frame(s, fl);
      exp_q.push_back((want == NOMODEL) ? m : want);
    end else if (fl) begin
      hist.delete();
    end
    @(posedge clk);
    #1;
    check({tag, "_valid"}, int'(out_valid), int'(exp_v));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_underflow"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check(tag, int'(sample_out), e);
        last_out = e;
      end
    end else begin
      check({tag, "_hold"}, int'(sample_out), last_out);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int imp[13];
    imp = '{8000, 0, 0, 0, 4000, 0, 0, 0, 2000, 0, 0, 0, 1000};

    // Reset held with new_frame toggling
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(i[0], 1'b0, 1234, NOMODEL, "reset");
    rst_n = 1'b1;
    step(1'b0, 1'b0, 0, NOMODEL, "idle");

    // Dry pass-through
    echo_en = 1'b0;
    step(1'b1, 1'b0, 1000, 1000, "dry");
    step(1'b0, 1'b0, 0, NOMODEL, "dry_idle");

    // Impulse response with flush on the impulse frame
    echo_en = 1'b1; delay_sel = 2'd0; atten = 2'd0;
    for (int i = 0; i < 13; i++)
      step(1'b1, (i == 0), (i == 0) ? 8000 : 0, imp[i], "impulse");

    // Saturation, positive then negative
    for (int i = 0; i < 8; i++)
      step(1'b1, (i == 0), 30000, (i < 4) ? 30000 : 32767, "sat_pos");
    for (int i = 0; i < 8; i++)
      step(1'b1, (i == 0), -30000, (i < 4) ? -30000 : -32768, "sat_neg");
    step(1'b0, 1'b0, 0, NOMODEL, "hold");
    step(1'b0, 1'b0, 0, NOMODEL, "hold");

    // Flush mid-stream
    atten = 2'd1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2000 + 100 * i, NOMODEL, "pre_flush");
    step(1'b0, 1'b1, 0, NOMODEL, "flush");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 500 + i, 500 + i, "post_flush_dry");
    step(1'b1, 1'b0, 700, 700 + (500 >>> 2), "post_flush_echo");

    // Back-to-back across pointer wrap, longest delay
    delay_sel = 2'd3; atten = 2'd0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1000 * (i + 1) - 9000, NOMODEL, "b2b");

    // Randomised traffic including settings changes and flush+frame collisions
    for (int i = 0; i < 120; i++) begin
      echo_en   = ($urandom_range(0, 7) != 0);
      delay_sel = 2'($urandom_range(0, 3));
      atten     = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
           $urandom_range(0, 65535) - 32768, NOMODEL, "rand");
    end

    // Reset mid-stream; stale memory must read as zero afterwards
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(~i[0], 1'b0, 4321, NOMODEL, "reset2");
    rst_n = 1'b1;
    echo_en = 1'b1; delay_sel = 2'd0; atten = 2'd0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 300 + i, 300 + i, "post_reset");
    step(1'b1, 1'b0, 0, 150, "post_reset_echo");
    step(1'b0, 1'b0, 0, NOMODEL, "final_idle");

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
